// File: rtl/cfc_checkpoint.sv
// Speculative rename table with a circular buffer of per-branch RAT/FRL-head snapshots.
// Lookups are combinational; a mispredict flush restores the RAT in one cycle.
module cfc_checkpoint #(
  parameter int NUM_CKPT   = 4,
  parameter int TAG_WIDTH  = 2,
  parameter int PHY_WIDTH  = 6,
  parameter int ARCH_WIDTH = 5,
  parameter int PTR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [ARCH_WIDTH-1:0] Dis_RsAddr,
  input  logic [ARCH_WIDTH-1:0] Dis_RtAddr,
  output logic [PHY_WIDTH-1:0]  Cfc_RsPhyAddr,
  output logic [PHY_WIDTH-1:0]  Cfc_RtPhyAddr,
  input  logic                  Dis_RegWrite,
  input  logic [ARCH_WIDTH-1:0] Dis_RdAddr,
  input  logic [PHY_WIDTH-1:0]  Dis_NewPhyAddr,
  output logic [PHY_WIDTH-1:0]  Cfc_RdPrePhyAddr,
  input  logic                  Dis_CkptReq,
  input  logic [PTR_WIDTH-1:0]  Frl_HeadPtr,
  output logic [TAG_WIDTH-1:0]  Cfc_CkptTag,
  output logic                  Cfc_Full,
  input  logic                  Cdb_BranchValid,
  input  logic [TAG_WIDTH-1:0]  Cdb_BranchTag,
  input  logic                  Cdb_Flush,
  output logic [PTR_WIDTH-1:0]  Cfc_FrlHeadPtr
);

  localparam int NUM_ARCH = 1 << ARCH_WIDTH;

  logic [PHY_WIDTH-1:0] rat      [NUM_ARCH];
  logic [PHY_WIDTH-1:0] ckpt_rat [NUM_CKPT][NUM_ARCH];
  logic [PTR_WIDTH-1:0] ckpt_ptr [NUM_CKPT];
  logic [NUM_CKPT-1:0]  valid;
  logic [NUM_CKPT-1:0]  valid_nxt;
  logic [TAG_WIDTH:0]   head;
  logic [TAG_WIDTH:0]   tail;
  logic [TAG_WIDTH:0]   flush_tail;
  logic [TAG_WIDTH-1:0] head_lo;
  logic [TAG_WIDTH-1:0] tail_lo;
  logic [TAG_WIDTH-1:0] flush_off;
  logic                 empty;
  logic                 flush;
  logic                 resolve;
  logic                 alloc;
  logic                 rename;
  logic                 retire;

  assign head_lo = head[TAG_WIDTH-1:0];
  assign tail_lo = tail[TAG_WIDTH-1:0];
  assign empty   = (head == tail);
  assign Cfc_Full = (head_lo == tail_lo) && (head[TAG_WIDTH] != tail[TAG_WIDTH]);
  assign Cfc_CkptTag = tail_lo;

  assign flush   = Cdb_BranchValid & Cdb_Flush;
  assign resolve = Cdb_BranchValid & ~Cdb_Flush;
  assign alloc   = Dis_CkptReq & ~Cfc_Full & ~flush;
  assign rename  = Dis_RegWrite & ~flush;
  // Retire looks at the registered valid bit, so a resolution drains one cycle later.
  assign retire  = ~empty & ~valid[head_lo];

  // Distance of the flushed slot from head equals the number of older slots kept.
  assign flush_off  = Cdb_BranchTag - head_lo;
  assign flush_tail = head + {1'b0, flush_off};

  assign Cfc_RsPhyAddr    = rat[Dis_RsAddr];
  assign Cfc_RtPhyAddr    = rat[Dis_RtAddr];
  assign Cfc_RdPrePhyAddr = rat[Dis_RdAddr];
  assign Cfc_FrlHeadPtr   = ckpt_ptr[Cdb_BranchTag];

  always_comb begin
    valid_nxt = valid;
    if (resolve)
      valid_nxt[Cdb_BranchTag] = 1'b0;
    if (flush) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if ((TAG_WIDTH'(i) - head_lo) >= flush_off)
          valid_nxt[i] = 1'b0;
      end
    end
    if (alloc)
      valid_nxt[tail_lo] = 1'b1;
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      valid <= valid_nxt;
      if (retire)
        head <= head + 1'b1;
      if (flush)
        tail <= flush_tail;
      else if (alloc)
        tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      for (int i = 0; i < NUM_ARCH; i++)
        rat[i] <= PHY_WIDTH'(i);
    end else if (flush) begin
      for (int i = 0; i < NUM_ARCH; i++)
        rat[i] <= ckpt_rat[Cdb_BranchTag][i];
    end else if (rename) begin
      rat[Dis_RdAddr] <= Dis_NewPhyAddr;
    end
  end

  // Snapshot storage needs no reset: a slot is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      for (int i = 0; i < NUM_ARCH; i++)
        ckpt_rat[tail_lo][i] <= rat[i];
      ckpt_ptr[tail_lo] <= Frl_HeadPtr;
    end
  end

endmodule

// File: tb/tb_cfc_checkpoint.sv
// Directed scenarios then random traffic, checked against a queue-style checkpoint model.
module tb_cfc_checkpoint;

  logic       clk = 1'b0;
  logic       resetb;
  logic [4:0] rs, rt, rd;
  logic [5:0] rs_phy, rt_phy, rd_pre, newp;
  logic       regw, ckreq, full, bv, bfl;
  logic [4:0] frlp, frl_out;
  logic [1:0] ck_tag, btag;

  int checks = 0;
  int failures = 0;

  // Reference model: slot contents plus head/tail as counters modulo 8.
  int m_rat [32];
  int m_ck_rat [4][32];
  int m_ck_ptr [4];
  bit m_valid [4];
  int m_head, m_tail;

  cfc_checkpoint dut (
    .clk(clk), .resetb(resetb),
    .Dis_RsAddr(rs), .Dis_RtAddr(rt),
    .Cfc_RsPhyAddr(rs_phy), .Cfc_RtPhyAddr(rt_phy),
    .Dis_RegWrite(regw), .Dis_RdAddr(rd), .Dis_NewPhyAddr(newp),
    .Cfc_RdPrePhyAddr(rd_pre),
    .Dis_CkptReq(ckreq), .Frl_HeadPtr(frlp),
    .Cfc_CkptTag(ck_tag), .Cfc_Full(full),
    .Cdb_BranchValid(bv), .Cdb_BranchTag(btag), .Cdb_Flush(bfl),
    .Cfc_FrlHeadPtr(frl_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    return (m_tail - m_head + 8) % 8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_head = 0;
    m_tail = 0;
  endtask

  task automatic model_step();
    int  h, cnt, keep;
    bit  v [4];
    bit  retire;
    int  old_rat [32];
    h      = m_head;
    cnt    = m_count();
    v      = m_valid;
    retire = (cnt != 0) && !m_valid[h % 4];
    if (bv && !bfl) v[btag] = 1'b0;
    if (bv && bfl) begin
      keep = (int'(btag) - h % 4 + 4) % 4;
      for (int k = keep; k < 4; k++) v[(h + k) % 4] = 1'b0;
      m_tail = (h + keep) % 8;
      m_rat  = m_ck_rat[btag];
    end else begin
      old_rat = m_rat;
      if (regw) m_rat[rd] = int'(newp);
      if (ckreq && cnt < 4) begin
        m_ck_rat[m_tail % 4] = old_rat;
        m_ck_ptr[m_tail % 4] = int'(frlp);
        v[m_tail % 4] = 1'b1;
        m_tail = (m_tail + 1) % 8;
      end
    end
    m_valid = v;
    if (retire) m_head = (h + 1) % 8;
  endtask

  task automatic check_model();
    chk("rs_lookup", int'(rs_phy), m_rat[rs]);
    chk("rt_lookup", int'(rt_phy), m_rat[rt]);
    chk("rd_prev",   int'(rd_pre), m_rat[rd]);
    chk("full",      int'(full),   int'(m_count() == 4));
    chk("ckpt_tag",  int'(ck_tag), m_tail % 4);
    if (m_valid[btag]) chk("frl_headptr", int'(frl_out), m_ck_ptr[btag]);
  endtask

  task automatic idle();
    regw = 0; ckreq = 0; bv = 0; bfl = 0;
    rs = 0; rt = 0; rd = 0; newp = 0; frlp = 0; btag = 0;
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetb = 1;
    model_reset();
    @(negedge clk);
    resetb = 0;
  endtask

  task automatic rename(input int a, input int p);
    idle(); regw = 1; rd = 5'(a); newp = 6'(p); tick();
  endtask

  task automatic alloc(input int p);
    idle(); ckreq = 1; frlp = 5'(p); tick();
  endtask

  task automatic resolve(input int t, input bit f);
    idle(); bv = 1; btag = 2'(t); bfl = f; tick();
  endtask

  initial begin
    int vq [$];
    idle();
    resetb = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetb = 0;

    // 1: reset state
    idle(); rs = 5; rt = 31; #1;
    chk("t1_rs", int'(rs_phy), 5);
    chk("t1_rt", int'(rt_phy), 31);
    chk("t1_full", int'(full), 0);
    chk("t1_tag", int'(ck_tag), 0);
    tick();

    // 2: rename, checkpoint, rename, flush
    rename(3, 32);
    alloc(1);
    rename(3, 33);
    idle(); bv = 1; bfl = 1; btag = 0; #1;
    chk("t2_frl_ptr", int'(frl_out), 1);
    tick();
    idle(); rs = 3; #1;
    chk("t2_r3_restored", int'(rs_phy), 32);
    chk("t2_tag", int'(ck_tag), 0);
    tick();

    // 3: fill, ignored request, resolve, wrap
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i + 4);
    idle(); #1;
    chk("t3_full", int'(full), 1);
    alloc(9);
    idle(); #1;
    chk("t3_ignored_tag", int'(ck_tag), 0);
    chk("t3_still_full", int'(full), 1);
    resolve(0, 0);
    idle(); tick();
    idle(); #1;
    chk("t3_not_full", int'(full), 0);
    chk("t3_next_tag", int'(ck_tag), 0);
    alloc(10);
    idle(); #1;
    chk("t3_wrap_full", int'(full), 1);
    tick();

    // 4: out-of-order resolutions and a flush of the youngest
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i);
    resolve(2, 0);
    resolve(1, 0);
    resolve(3, 1);
    idle(); #1;
    chk("t4_tail_tag", int'(ck_tag), 3);
    chk("t4_full", int'(full), 0);
    resolve(0, 0);
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    for (int i = 0; i < 4; i++) begin
      idle(); #1;
      chk("t4_drain_tag", int'(ck_tag), (3 + i) % 4);
      chk("t4_drain_notfull", int'(full), 0);
      alloc(i);
    end
    idle(); #1;
    chk("t4_refill_full", int'(full), 1);
    tick();

    // 5: flush with a colliding rename and allocation
    do_reset();
    rename(7, 20);
    alloc(2);
    rename(7, 21);
    alloc(3);
    rename(7, 22);
    idle(); bv = 1; bfl = 1; btag = 1; regw = 1; rd = 7; newp = 40; ckreq = 1; frlp = 7;
    tick();
    idle(); rs = 7; #1;
    chk("t5_r7", int'(rs_phy), 21);
    chk("t5_tag", int'(ck_tag), 1);
    tick();

    // 6: asynchronous reset with checkpoints outstanding
    do_reset();
    rename(9, 50);
    for (int i = 0; i < 3; i++) alloc(i);
    idle(); rs = 9;
    #2 resetb = 1;
    #1;
    model_reset();
    chk("t6_rat_identity", int'(rs_phy), 9);
    chk("t6_full", int'(full), 0);
    chk("t6_tag", int'(ck_tag), 0);
    @(negedge clk);
    resetb = 0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      newp = 6'($urandom); frlp = 5'($urandom);
      btag = 2'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        if ($urandom_range(2, 0) == 0) ckreq = 1; else regw = 1;
      end
      vq.delete();
      for (int i = 0; i < 4; i++) if (m_valid[i]) vq.push_back(i);
      if (vq.size() != 0 && $urandom_range(2, 0) == 0) begin
        bv   = 1;
        btag = 2'(vq[$urandom_range(vq.size() - 1, 0)]);
        bfl  = ($urandom_range(5, 0) == 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfc_checkpoint.md
Name: cfc_checkpoint

Overview:
- Checkpointed speculative rename table (CFC) for the out-of-order MIPS core; sits between Dispatch and the Free Register List.
- Holds the speculative RAT (architectural to physical mapping) and feeds rename lookups to Dispatch.
- On every dispatched branch, snapshots the RAT and the FRL head pointer into a circular checkpoint buffer.
- On a CDB flush, restores the RAT from the mispredicted branch's checkpoint and drives Cfc_FrlHeadPtr so the FRL can rewind its head.

Parameters:
NUM_CKPT, 4, number of checkpoint slots (power of two)
TAG_WIDTH, 2, log2(NUM_CKPT); branch tag equals slot index
PHY_WIDTH, 6, physical register address width
ARCH_WIDTH, 5, architectural register address width (32 regs)
PTR_WIDTH, 5, FRL head pointer width

Ports:
clk  in  1  clock, rising edge
resetb  in  1  asynchronous reset, active-high
Dis_RsAddr  in  ARCH_WIDTH  source 1 lookup address
Dis_RtAddr  in  ARCH_WIDTH  source 2 lookup address
Cfc_RsPhyAddr  out  PHY_WIDTH  combinational mapping of Dis_RsAddr
Cfc_RtPhyAddr  out  PHY_WIDTH  combinational mapping of Dis_RtAddr
Dis_RegWrite  in  1  rename write enable
Dis_RdAddr  in  ARCH_WIDTH  destination architectural register
Dis_NewPhyAddr  in  PHY_WIDTH  physical register just taken from the FRL
Cfc_RdPrePhyAddr  out  PHY_WIDTH  combinational current mapping of Dis_RdAddr (old mapping, sent to ROB)
Dis_CkptReq  in  1  allocate checkpoint for dispatched branch
Frl_HeadPtr  in  PTR_WIDTH  FRL head pointer to snapshot
Cfc_CkptTag  out  TAG_WIDTH  tag that the next allocation will use (slot at tail)
Cfc_Full  out  1  no free checkpoint slot
Cdb_BranchValid  in  1  branch resolved on CDB this cycle
Cdb_BranchTag  in  TAG_WIDTH  tag of resolved branch
Cdb_Flush  in  1  resolved branch mispredicted (qualified by Cdb_BranchValid)
Cfc_FrlHeadPtr  out  PTR_WIDTH  combinational saved head pointer of slot Cdb_BranchTag

Behaviour:
- Reset: RAT[i] = i for i = 0..31, which matches the FRL's initial contents of 32..47. All slot valid bits = 0, head = tail = 0 (TAG_WIDTH+1 bits, including wrap bit). Cfc_Full = 0, Cfc_CkptTag = 0. Checkpoint storage contents are don't-care.
- Lookups (Rs, Rt, Rd-previous) are combinational from the current RAT. A same-cycle rename write is not bypassed.
- Rename: if Dis_RegWrite and no flush, RAT[Dis_RdAddr] <= Dis_NewPhyAddr at the edge. Write to arch reg 0 is performed like any other write.
- Dis_CkptReq and Dis_RegWrite are mutually exclusive; Dispatch guarantees this because branches have no destination. The block does not check it.
- Allocate: if Dis_CkptReq and !Cfc_Full and no flush, then slot[tail] <= {current RAT, Frl_HeadPtr}, valid[tail] <= 1, tail <= tail + 1.
- Dis_CkptReq while Cfc_Full is ignored. Dispatch must stall on Cfc_Full.
- Cfc_Full = (head and tail low bits equal) and (wrap bits differ).
- Correct resolution: Cdb_BranchValid & !Cdb_Flush clears valid[Cdb_BranchTag].
- Head retire: each cycle, if head != tail and valid[head] == 0, then head <= head + 1. At most one slot retires per cycle, so out-of-order resolutions drain one per cycle.
- Flush (Cdb_BranchValid & Cdb_Flush, tag t):
  - RAT <= slot[t].RAT in one cycle.
  - Valid bits of t and every younger slot (t up to tail-1, circular) are cleared.
  - tail <= head + ((t - head_low) mod NUM_CKPT), keeping the wrap bit consistent.
  - Same-cycle rename writes and allocations are dropped.
  - Same-cycle head retire still applies to slots older than t.
- Cfc_FrlHeadPtr = slot[Cdb_BranchTag].headptr at all times, combinational. The FRL samples it on the flush edge, so there is zero latency.
- A flush tag naming an invalid slot is illegal; behaviour is unspecified, and the bench asserts it never happens.
- Wrap-around: pointers increment modulo 2*NUM_CKPT; slot index = low TAG_WIDTH bits.
- Reset asserted mid-operation returns the block immediately to the reset state.

Test Plan:
1. Reset, then lookup Rs=5, Rt=31 -> Cfc_RsPhyAddr=5, Cfc_RtPhyAddr=31. Cfc_Full=0, Cfc_CkptTag=0.
2. Rename r3->32, then Dis_CkptReq with Frl_HeadPtr=1, then rename r3->33, then flush tag 0 -> next cycle r3 maps to 32, Cfc_FrlHeadPtr=1 during the flush cycle, and Cfc_CkptTag=0.
3. Allocate 4 checkpoints -> Cfc_Full=1 and a 5th request is ignored. Resolve tag 0 correct -> Cfc_Full=0 one cycle later, and the next allocation gets tag 0 with the wrap bit toggled.
4. Allocate tags 0..3, resolve 2 then 1 correct, then flush tag 3 -> head stays at 0, tail = 3. Then resolve 0 correct -> head advances through 0, 1, 2 over 3 cycles and the buffer becomes empty.
5. Flush tag 1 in the same cycle as Dis_RegWrite r7->40 and Dis_CkptReq -> RAT equals the checkpoint-1 copy, r7 is not 40, and no new slot is allocated.
6. Assert resetb mid-sequence with 3 valid checkpoints -> RAT returns to identity, Cfc_Full=0, Cfc_CkptTag=0 immediately.
